// File: rtl/axil_reg_bank_pkg.sv
// Shared constants and address helpers for the AXI-lite control/status register bank.
package axil_reg_bank_pkg;

  localparam int unsigned IDX_CTRL     = 0;
  localparam int unsigned IDX_IRQ_STAT = 1;
  localparam int unsigned IDX_IRQ_MASK = 2;
  localparam int unsigned IDX_CFG_BASE = 3;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_BUSY  = 1;

  // Callers zero-extend narrower addresses, so the full upper range takes part in the compare.
  localparam int unsigned IDX_W = 64;

  function automatic logic [IDX_W-1:0] idx_of(input logic [IDX_W-1:0] addr);
    return addr >> 2;
  endfunction

endpackage

// File: rtl/axil_reg_bank_if.sv
// Register-interface strobes between the AXI-lite adapters (master) and the register bank (slave).
interface axil_reg_bank_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 40,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);

  logic [ADDR_WIDTH-1:0] reg_rd_addr;
  logic                  reg_rd_en;
  logic [DATA_WIDTH-1:0] reg_rd_data;
  logic                  reg_rd_wait;
  logic                  reg_rd_ack;

  logic [ADDR_WIDTH-1:0] reg_wr_addr;
  logic [DATA_WIDTH-1:0] reg_wr_data;
  logic [STRB_WIDTH-1:0] reg_wr_strb;
  logic                  reg_wr_en;
  logic                  reg_wr_wait;
  logic                  reg_wr_ack;

  modport master (
    output reg_rd_addr, reg_rd_en, reg_wr_addr, reg_wr_data, reg_wr_strb, reg_wr_en,
    input  reg_rd_data, reg_rd_wait, reg_rd_ack, reg_wr_wait, reg_wr_ack
  );

  modport slave (
    input  reg_rd_addr, reg_rd_en, reg_wr_addr, reg_wr_data, reg_wr_strb, reg_wr_en,
    output reg_rd_data, reg_rd_wait, reg_rd_ack, reg_wr_wait, reg_wr_ack
  );

endinterface

// File: rtl/axil_reg_bank_irq.sv
// Sticky interrupt status with read/W1C clears and a registered masked interrupt output.
module axil_reg_bank_irq #(
  parameter int unsigned N_IRQ = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_set_i,
  input  logic [N_IRQ-1:0] rd_clr_i,
  input  logic [N_IRQ-1:0] wr_clr_i,
  input  logic [N_IRQ-1:0] irq_mask_i,
  output logic [N_IRQ-1:0] irq_stat_o,
  output logic             irq_o
);

  logic [N_IRQ-1:0] irq_stat_q, irq_stat_d;
  logic             irq_q;

  // A new event on the same edge as a clear must not be lost, so set is OR-ed in last.
  always_comb begin
    irq_stat_d = (irq_stat_q & ~rd_clr_i & ~wr_clr_i) | irq_set_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_stat_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_stat_q <= irq_stat_d;
      irq_q      <= |(irq_stat_q & irq_mask_i);
    end
  end

  assign irq_stat_o = irq_stat_q;
  assign irq_o      = irq_q;

endmodule

// File: rtl/axil_reg_bank.sv
// Control/status register file behind the AXI-lite register adapters: config words, status
// words, start pulse and maskable sticky interrupt.
module axil_reg_bank
  import axil_reg_bank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 40,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned N_CFG      = 16,
  parameter int unsigned N_STAT     = 8,
  parameter int unsigned N_IRQ      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  axil_reg_bank_if.slave               bus,
  output logic [N_CFG*DATA_WIDTH-1:0]  cfg_o,
  input  logic [N_STAT*DATA_WIDTH-1:0] stat_i,
  input  logic                         busy_i,
  input  logic [N_IRQ-1:0]             irq_set_i,
  output logic                         start_o,
  output logic                         irq_o
);

  localparam int unsigned IDX_STAT_BASE = IDX_CFG_BASE + N_CFG;

  logic [DATA_WIDTH-1:0] cfg_q [N_CFG];
  logic [N_IRQ-1:0]      irq_mask_q;
  logic [N_IRQ-1:0]      irq_stat;

  logic                  rd_ack_q, wr_ack_q;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  start_q, start_d;

  logic                  rd_fire, wr_fire;
  logic [IDX_W-1:0]      rd_idx, wr_idx;
  logic [N_IRQ-1:0]      rd_sel_clr, rd_clr, wr_clr;
  logic [DATA_WIDTH-1:0] byte_mask;

  // En stays high through the ack cycle, so the registered ack suppresses a second fire.
  assign rd_fire = bus.reg_rd_en && !rd_ack_q;
  assign wr_fire = bus.reg_wr_en && !wr_ack_q;

  assign rd_idx = idx_of(IDX_W'(bus.reg_rd_addr));
  assign wr_idx = idx_of(IDX_W'(bus.reg_wr_addr));

  always_comb begin
    byte_mask = '0;
    for (int b = 0; b < STRB_WIDTH; b++) begin
      byte_mask[b*8 +: 8] = {8{bus.reg_wr_strb[b]}};
    end
  end

  // Read decode; STAT is sampled here so the data reflects the acking edge.
  always_comb begin
    rd_data_d  = '0;
    rd_sel_clr = '0;
    if (rd_idx == IDX_W'(IDX_CTRL)) begin
      rd_data_d[CTRL_BUSY] = busy_i;
    end else if (rd_idx == IDX_W'(IDX_IRQ_STAT)) begin
      rd_data_d  = DATA_WIDTH'(irq_stat);
      rd_sel_clr = irq_stat;
    end else if (rd_idx == IDX_W'(IDX_IRQ_MASK)) begin
      rd_data_d = DATA_WIDTH'(irq_mask_q);
    end
    for (int k = 0; k < N_CFG; k++) begin
      if (rd_idx == IDX_W'(IDX_CFG_BASE) + IDX_W'(k)) rd_data_d = cfg_q[k];
    end
    for (int k = 0; k < N_STAT; k++) begin
      if (rd_idx == IDX_W'(IDX_STAT_BASE) + IDX_W'(k)) rd_data_d = stat_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign rd_clr = rd_fire ? rd_sel_clr : '0;

  always_comb begin
    wr_clr  = '0;
    start_d = 1'b0;
    if (wr_fire) begin
      if (wr_idx == IDX_W'(IDX_CTRL)) begin
        start_d = bus.reg_wr_data[CTRL_START] && bus.reg_wr_strb[CTRL_START/8];
      end
      if (wr_idx == IDX_W'(IDX_IRQ_STAT)) begin
        wr_clr = N_IRQ'(bus.reg_wr_data & byte_mask);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ack_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_data_q  <= '0;
      start_q    <= 1'b0;
      irq_mask_q <= '0;
      for (int k = 0; k < N_CFG; k++) cfg_q[k] <= '0;
    end else begin
      rd_ack_q <= rd_fire;
      wr_ack_q <= wr_fire;
      start_q  <= start_d;
      if (rd_fire) rd_data_q <= rd_data_d;
      if (wr_fire && wr_idx == IDX_W'(IDX_IRQ_MASK)) begin
        irq_mask_q <= N_IRQ'((DATA_WIDTH'(irq_mask_q) & ~byte_mask) |
                             (bus.reg_wr_data & byte_mask));
      end
      for (int k = 0; k < N_CFG; k++) begin
        if (wr_fire && wr_idx == IDX_W'(IDX_CFG_BASE) + IDX_W'(k)) begin
          cfg_q[k] <= (cfg_q[k] & ~byte_mask) | (bus.reg_wr_data & byte_mask);
        end
      end
    end
  end

  for (genvar g = 0; g < N_CFG; g++) begin : g_cfg_pack
    assign cfg_o[g*DATA_WIDTH +: DATA_WIDTH] = cfg_q[g];
  end

  axil_reg_bank_irq #(
    .N_IRQ (N_IRQ)
  ) u_irq (
    .clk        (clk),
    .rst        (rst),
    .irq_set_i  (irq_set_i),
    .rd_clr_i   (rd_clr),
    .wr_clr_i   (wr_clr),
    .irq_mask_i (irq_mask_q),
    .irq_stat_o (irq_stat),
    .irq_o      (irq_o)
  );

  assign bus.reg_rd_data = rd_data_q;
  assign bus.reg_rd_ack  = rd_ack_q;
  assign bus.reg_rd_wait = 1'b0;
  assign bus.reg_wr_ack  = wr_ack_q;
  assign bus.reg_wr_wait = 1'b0;
  assign start_o         = start_q;

endmodule
